cordic_ctl: RTL and testbench

- Sequencing controller for the two-phase CORDIC datapath. It drives the datapath control inputs: mux select, counter reset and counter hold.
- It accepts a start request with a mode, loads operands, runs a fixed number of iterations, then presents a result-valid handshake.
- It monitors the datapath iteration counter and flags sequencing errors.
- It sits between the system-level host/bus logic and the datapath.

---
 rtl/cordic_ctl.sv | 120 ++++++++++++
 tb/tb_cordic_ctl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_ctl.sv
// Sequencing controller for the two-phase CORDIC datapath.
// Accepts a start request with a mode and loads the operands for one cycle.
// It then runs ITERATIONS feedback cycles while cross-checking the datapath
// iteration counter, and holds the result under a valid/ready handshake.
// Every output is registered.
module cordic_ctl #(
  parameter int unsigned ITERATIONS = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clka,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic             cordic_mode,
  output logic [1:0]       in_mux_ctl,
  output logic             counter_rst,
  output logic             counter_hold,
  input  logic [CNT_W-1:0] counter
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    ITER   = 2'b10,
    RESULT = 2'b11
  } state_t;

  localparam logic [1:0] MUX_ROT  = 2'b00;
  localparam logic [1:0] MUX_VEC  = 2'b10;
  localparam logic [1:0] MUX_FB   = 2'b01;
  localparam logic [1:0] MUX_HOLD = 2'b11;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  state_t           state;
  logic [CNT_W-1:0] iter_cnt;

  // Sequencer: state plus registered datapath controls and handshake flags.
  // Each branch assigns the output values for the state being entered.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      err          <= 1'b0;
      cordic_mode  <= 1'b0;
      in_mux_ctl   <= MUX_HOLD;
      counter_rst  <= 1'b0;
      counter_hold <= 1'b1;
      iter_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_mux_ctl   <= MUX_HOLD;
          counter_hold <= 1'b1;
          counter_rst  <= 1'b0;
          busy         <= 1'b0;
          out_valid    <= 1'b0;
          if (start) begin
            state        <= LOAD;
            cordic_mode  <= mode_in;
            err          <= 1'b0;
            busy         <= 1'b1;
            in_mux_ctl   <= mode_in ? MUX_VEC : MUX_ROT;
            counter_rst  <= 1'b1;
            counter_hold <= 1'b0;
            iter_cnt     <= '0;
          end
        end

        LOAD: begin
          state        <= ITER;
          in_mux_ctl   <= MUX_FB;
          counter_rst  <= 1'b0;
          counter_hold <= 1'b0;
          iter_cnt     <= '0;
        end

        ITER: begin
          // A counter mismatch is recorded but the operation still completes.
          if (counter != iter_cnt) begin
            err <= 1'b1;
          end
          if (iter_cnt == LAST_ITER) begin
            state        <= RESULT;
            in_mux_ctl   <= MUX_HOLD;
            counter_hold <= 1'b1;
            out_valid    <= 1'b1;
          end else begin
            iter_cnt <= iter_cnt + CNT_W'(1);
          end
        end

        RESULT: begin
          // A start arriving together with out_ready is dropped.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          out_valid    <= 1'b0;
          in_mux_ctl   <= MUX_HOLD;
          counter_rst  <= 1'b0;
          counter_hold <= 1'b1;
          iter_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_ctl.sv
// Self-checking bench for cordic_ctl.
// The reference model tracks each operation as a position on a timeline:
// -1 is idle, 0 is the load cycle, 1..ITER are the iterations, and ITER+1 is
// waiting for the result to be accepted.
module tb_cordic_ctl;

  localparam int ITER = 8;

  logic       clka;
  logic       reset;
  logic       start;
  logic       mode_in;
  logic       out_ready;
  logic [3:0] cnt_drv;
  logic       busy;
  logic       out_valid;
  logic       err;
  logic       cordic_mode;
  logic [1:0] in_mux_ctl;
  logic       counter_rst;
  logic       counter_hold;

  int n_chk = 0;
  int n_err = 0;
  int ncyc = 0;
  int dut_results = 0;
  int m_results = 0;
  int m_pos = -1;
  logic m_mode = 1'b0;
  logic m_err = 1'b0;
  logic chk_en = 1'b0;
  logic inject = 1'b0;

  cordic_ctl #(.ITERATIONS(ITER), .CNT_W(4)) dut (
    .clka        (clka),
    .reset       (reset),
    .start       (start),
    .mode_in     (mode_in),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err         (err),
    .cordic_mode (cordic_mode),
    .in_mux_ctl  (in_mux_ctl),
    .counter_rst (counter_rst),
    .counter_hold(counter_hold),
    .counter     (cnt_drv)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  always @(posedge clka) ncyc++;

  always @(posedge clka) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) dut_results++;
  end

  // Emulated datapath counter: equals the iteration index during the
  // iterations, and the fault injection corrupts the expected value 3 into 5.
  always_comb begin
    cnt_drv = '0;
    if (m_pos >= 1 && m_pos <= ITER) cnt_drv = 4'(m_pos - 1);
    if (inject && m_pos == 4) cnt_drv = 4'd5;
  end

  // Reference timeline.
  always @(posedge clka or negedge reset) begin
    if (!reset) begin
      m_pos  <= -1;
      m_mode <= 1'b0;
      m_err  <= 1'b0;
    end else if (m_pos < 0) begin
      if (start) begin
        m_pos  <= 0;
        m_mode <= mode_in;
        m_err  <= 1'b0;
      end
    end else if (m_pos <= ITER) begin
      if (m_pos >= 1 && cnt_drv != 4'(m_pos - 1)) m_err <= 1'b1;
      m_pos <= m_pos + 1;
    end else if (out_ready) begin
      m_pos     <= -1;
      m_results <= m_results + 1;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the timeline.
  always @(negedge clka) begin
    if (chk_en) begin
      logic [1:0] e_mux;
      if (m_pos == 0) e_mux = {m_mode, 1'b0};
      else if (m_pos >= 1 && m_pos <= ITER) e_mux = 2'b01;
      else e_mux = 2'b11;
      chk("busy", 8'(busy), 8'(m_pos >= 0));
      chk("out_valid", 8'(out_valid), 8'(m_pos == ITER + 1));
      chk("in_mux_ctl", 8'(in_mux_ctl), 8'(e_mux));
      chk("counter_rst", 8'(counter_rst), 8'(m_pos == 0));
      chk("counter_hold", 8'(counter_hold), 8'(!(m_pos >= 0 && m_pos <= ITER)));
      chk("cordic_mode", 8'(cordic_mode), 8'(m_mode));
      chk("err", 8'(err), 8'(m_err));
    end
  end

  // Returns at the negedge following the accepting edge (DUT in load cycle).
  task automatic start_op(input logic m, output int t0);
    @(negedge clka);
    start   = 1'b1;
    mode_in = m;
    @(negedge clka);
    start = 1'b0;
    t0    = ncyc;
  endtask

  // Latency counts edges from the accepting edge to the first edge that
  // samples out_valid high.
  task automatic wait_valid(input int t0, output int lat);
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (out_valid === 1'b1) begin
        lat = ncyc - t0 + 1;
        break;
      end
      @(negedge clka);
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clka);
    out_ready = 1'b0;
    chk("ack_out_valid", 8'(out_valid), 8'd0);
    chk("ack_busy", 8'(busy), 8'd0);
  endtask

  initial begin
    int t0;
    int lat;
    reset = 1'b0; start = 1'b0; mode_in = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    chk("rst_cordic_mode", 8'(cordic_mode), 8'd0);
    chk("rst_in_mux", 8'(in_mux_ctl), 8'h3);
    chk("rst_counter_rst", 8'(counter_rst), 8'd0);
    chk("rst_counter_hold", 8'(counter_hold), 8'd1);
    chk_en = 1'b1;
    @(negedge clka);
    reset = 1'b1;

    // Rotation
    start_op(1'b0, t0);
    chk("rot_load_mux", 8'(in_mux_ctl), 8'h0);
    chk("rot_load_crst", 8'(counter_rst), 8'd1);
    chk("rot_load_busy", 8'(busy), 8'd1);
    @(negedge clka);
    chk("rot_iter_mux", 8'(in_mux_ctl), 8'h1);
    wait_valid(t0, lat);
    chk("rot_latency", 8'(lat), 8'd10);
    repeat (5) begin
      @(negedge clka);
      chk("rot_hold_valid", 8'(out_valid), 8'd1);
    end
    ack();

    // Vectoring, with mode_in toggling during the iterations
    start_op(1'b1, t0);
    chk("vec_mode", 8'(cordic_mode), 8'd1);
    chk("vec_load_mux", 8'(in_mux_ctl), 8'h2);
    repeat (4) begin
      @(negedge clka);
      mode_in = ~mode_in;
    end
    @(negedge clka);
    chk("vec_mode_held", 8'(cordic_mode), 8'd1);
    wait_valid(t0, lat);
    chk("vec_latency", 8'(lat), 8'd10);
    ack();

    // start while busy is ignored
    start_op(1'b0, t0);
    repeat (4) @(negedge clka);
    start = 1'b1; mode_in = 1'b1;
    @(negedge clka);
    start = 1'b0; mode_in = 1'b0;
    chk("busy_rej_mode", 8'(cordic_mode), 8'd0);
    wait_valid(t0, lat);
    chk("busy_rej_latency", 8'(lat), 8'd10);
    ack();
    repeat (12) @(negedge clka);
    chk("busy_rej_no_second", 8'(out_valid | busy), 8'd0);

    // Counter mismatch sets sticky err, next start clears it
    inject = 1'b1;
    start_op(1'b0, t0);
    wait_valid(t0, lat);
    chk("mism_latency", 8'(lat), 8'd10);
    chk("mism_err", 8'(err), 8'd1);
    ack();
    chk("mism_err_sticky", 8'(err), 8'd1);
    inject = 1'b0;
    start_op(1'b0, t0);
    chk("mism_err_cleared", 8'(err), 8'd0);
    wait_valid(t0, lat);
    ack();

    // Asynchronous reset during the third iteration
    start_op(1'b1, t0);
    repeat (3) @(negedge clka);
    #2 reset = 1'b0;
    #1;
    chk("arst_in_mux", 8'(in_mux_ctl), 8'h3);
    chk("arst_hold", 8'(counter_hold), 8'd1);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_valid", 8'(out_valid), 8'd0);
    chk("arst_mode", 8'(cordic_mode), 8'd0);
    @(negedge clka);
    reset = 1'b1;
    start_op(1'b0, t0);
    wait_valid(t0, lat);
    chk("arst_latency", 8'(lat), 8'd10);
    ack();

    // start together with out_ready in the result phase is dropped
    start_op(1'b0, t0);
    wait_valid(t0, lat);
    start = 1'b1; mode_in = 1'b1; out_ready = 1'b1;
    @(negedge clka);
    start = 1'b0; out_ready = 1'b0;
    chk("simul_busy", 8'(busy), 8'd0);
    chk("simul_valid", 8'(out_valid), 8'd0);
    chk("simul_mode", 8'(cordic_mode), 8'd0);
    start_op(1'b1, t0);
    chk("simul_next_busy", 8'(busy), 8'd1);
    chk("simul_next_mode", 8'(cordic_mode), 8'd1);
    chk("simul_next_mux", 8'(in_mux_ctl), 8'h2);
    wait_valid(t0, lat);
    chk("simul_next_latency", 8'(lat), 8'd10);
    ack();

    repeat (3) @(negedge clka);
    chk("result_count_model", 8'(dut_results), 8'(m_results));
    chk("result_count", 8'(dut_results), 8'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
